fp_addsub_result_collector: RTL and testbench

- Sits directly downstream of the floating-point add/sub unit.
- Tracks every FADD/FSUB issued into the fixed-latency adder pipeline with its destination register tag, captures the adder result and exception flags when they emerge, and buffers them in a small FIFO for the FP register-file writeback port.
- Accumulates the sticky IEEE-754 exception flags and drives the functional-unit FREE/BUSY state to the dispatcher.

---
 rtl/fp_addsub_result_collector_pkg.sv | 32 +++
 rtl/fp_addsub_result_collector_if.sv | 39 +++
 rtl/fp_addsub_result_collector_chk.sv | 20 ++
 rtl/fp_addsub_result_collector_sync_fifo.sv | 59 +++++
 rtl/fp_addsub_result_collector.sv | 136 +++++++++++++
 tb/tb_fp_addsub_result_collector.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_addsub_result_collector_pkg.sv
// Shared types for the FP add/sub result collector: float/exception types,
// writeback entry layout and the functional-unit state reported to dispatch.
package fp_addsub_result_collector_pkg;

    typedef logic [31:0] float_t;

    typedef enum logic [0:0] {
        FU_FREE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

    localparam int FP_ADD_LATENCY = 4;
    localparam int FP_TAG_W       = 5;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_exc_t;

    typedef struct packed {
        logic [FP_TAG_W-1:0] tag;
        float_t              data;
        fp_exc_t             flags;
    } fp_wb_entry_t;

    // Sticky accumulation of IEEE-754 exception bits.
    function automatic fp_exc_t exc_merge(input fp_exc_t acc, input fp_exc_t add);
        return fp_exc_t'(acc | add);
    endfunction

endpackage

// File: rtl/fp_addsub_result_collector_if.sv
// Issue / adder-result / writeback bundle between the dispatcher side (master)
// and the result collector (slave).
interface fp_addsub_result_collector_if
    import fp_addsub_result_collector_pkg::*;
#(
    parameter int TAG_W = FP_TAG_W
) ();

    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [TAG_W-1:0] issue_rd_i;
    float_t           add_result_i;
    logic             add_underflow_i;
    logic             add_overflow_i;
    logic             add_invalid_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [TAG_W-1:0] wb_rd_o;
    float_t           wb_data_o;
    fp_exc_t          wb_flags_o;
    fp_exc_t          fflags_o;
    logic             fflags_clr_i;
    fu_state_e        fu_state_o;

    modport master (
        output issue_valid_i, issue_rd_i, add_result_i, add_underflow_i,
               add_overflow_i, add_invalid_i, wb_ready_i, fflags_clr_i,
        input  issue_ready_o, wb_valid_o, wb_rd_o, wb_data_o, wb_flags_o,
               fflags_o, fu_state_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, add_result_i, add_underflow_i,
               add_overflow_i, add_invalid_i, wb_ready_i, fflags_clr_i,
        output issue_ready_o, wb_valid_o, wb_rd_o, wb_data_o, wb_flags_o,
               fflags_o, fu_state_o
    );

endinterface

// File: rtl/fp_addsub_result_collector_chk.sv
// Protocol checks for the result collector: no issue without credit and no
// adder capture into a full result buffer.
module fp_addsub_result_collector_chk (
    input logic clk_i,
    input logic rst_i,
    input logic issue_valid_i,
    input logic issue_ready_i,
    input logic capture_i,
    input logic fifo_full_i
);

    a_issue_without_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        !(issue_valid_i && !issue_ready_i))
        else $error("issue_valid asserted while issue_ready is low");

    a_capture_into_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(capture_i && fifo_full_i))
        else $error("adder result captured while result buffer is full");

endmodule

// File: rtl/fp_addsub_result_collector_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
module fp_addsub_result_collector_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign full_o    = (count_r == CNT_W'(DEPTH));
    assign empty_o   = (count_r == CNT_W'(0));
    assign count_o   = count_r;
    assign rdata_o   = mem_r[rd_ptr_r];

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_addsub_result_collector.sv
// Tracks FADD/FSUB ops through the fixed-latency adder, buffers results for FP
// writeback and accumulates sticky flags. Option: FP_RESULT_BYPASS_EN.
module fp_addsub_result_collector
    import fp_addsub_result_collector_pkg::*;
#(
    parameter int LATENCY    = FP_ADD_LATENCY,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = FP_TAG_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clk_en_i,
    fp_addsub_result_collector_if.slave   bus
);

    localparam int ENTRY_W = TAG_W + 32 + 3;
    localparam int INF_W   = $clog2(LATENCY + 1);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W   = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;

    logic [LATENCY-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r [LATENCY];
    logic [INF_W-1:0]   inflight_r;
    fp_exc_t            fflags_r;

    logic               accept_s;
    logic               capture_s;
    logic               bypass_s;
    logic               push_s;
    logic               pop_s;
    logic               fifo_pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [ENTRY_W-1:0] cap_entry_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic [ENTRY_W-1:0] wb_entry_s;

    assign accept_s    = bus.issue_valid_i & bus.issue_ready_o & clk_en_i;
    assign capture_s   = valid_r[LATENCY-1] & clk_en_i & ~rst_i;
    assign cap_entry_s = {tag_r[LATENCY-1], bus.add_result_i,
                          bus.add_invalid_i, bus.add_overflow_i, bus.add_underflow_i};

`ifdef FP_RESULT_BYPASS_EN
    assign bypass_s = capture_s & fifo_empty_s;
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed entry accepted by writeback never occupies a FIFO slot.
    assign push_s     = capture_s & ~(bypass_s & bus.wb_ready_i);
    assign wb_entry_s = bypass_s ? cap_entry_s : fifo_rdata_s;
    assign pop_s      = bus.wb_valid_o & bus.wb_ready_i;
    assign fifo_pop_s = pop_s & ~bypass_s;

    assign bus.wb_valid_o    = ~fifo_empty_s | bypass_s;
    assign bus.wb_rd_o       = wb_entry_s[ENTRY_W-1 -: TAG_W];
    assign bus.wb_data_o     = wb_entry_s[34:3];
    assign bus.wb_flags_o    = fp_exc_t'(wb_entry_s[2:0]);
    assign bus.fflags_o      = fflags_r;
    assign bus.fu_state_o    = (inflight_r != INF_W'(0)) ? FU_BUSY : FU_FREE;
    assign bus.issue_ready_o = ~rst_i &
        ((SUM_W'(inflight_r) + SUM_W'(fifo_count_s)) < SUM_W'(FIFO_DEPTH));

    // Valid bits of the adder shadow pipeline; frozen together with the adder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= {LATENCY{1'b0}};
        end else if (clk_en_i) begin
            valid_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) valid_r[i] <= valid_r[i-1];
        end else begin
            valid_r <= valid_r;
        end
    end

    // Destination tags travel alongside the valid bits.
    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            tag_r[0] <= bus.issue_rd_i;
            for (int i = 1; i < LATENCY; i++) tag_r[i] <= tag_r[i-1];
        end
    end

    // In-flight op count: one per valid shadow stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_r <= INF_W'(0);
        end else begin
            case ({accept_s, capture_s})
                2'b10:   inflight_r <= inflight_r + INF_W'(1);
                2'b01:   inflight_r <= inflight_r - INF_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Sticky exception flags; a popped entry's flags survive a coincident clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_r <= fp_exc_t'(3'b000);
        end else if (pop_s) begin
            fflags_r <= exc_merge(bus.fflags_clr_i ? fp_exc_t'(3'b000) : fflags_r,
                                  bus.wb_flags_o);
        end else if (bus.fflags_clr_i) begin
            fflags_r <= fp_exc_t'(3'b000);
        end else begin
            fflags_r <= fflags_r;
        end
    end

    fp_addsub_result_collector_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .wdata_i (cap_entry_s),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    fp_addsub_result_collector_chk u_chk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (bus.issue_valid_i),
        .issue_ready_i (bus.issue_ready_o),
        .capture_i     (capture_s),
        .fifo_full_i   (fifo_full_s)
    );

endmodule

// File: tb/tb_fp_addsub_result_collector.sv
// Scoreboard bench for fp_addsub_result_collector with a behavioural adder pipeline.
`timescale 1ns/1ps
module tb_fp_addsub_result_collector;
    import fp_addsub_result_collector_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
    localparam int TW    = 5;
`ifdef FP_RESULT_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    logic clk_en_i;

    fp_addsub_result_collector_if #(.TAG_W(TW)) bus ();

    fp_addsub_result_collector #(
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH),
        .TAG_W      (TW)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clk_en_i (clk_en_i),
        .bus      (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int           n_chk  = 0;
    int           n_pass = 0;
    fp_wb_entry_t sb[$];
    float_t       cur_res;
    fp_exc_t      cur_flg;
    float_t       a_res [LAT];
    fp_exc_t      a_flg [LAT];
    fp_exc_t      exp_ff = 3'b000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural adder: fixed latency, stalls with clk_en_i, not reset.
    always @(posedge clk_i) begin
        if (clk_en_i) begin
            for (int i = LAT - 1; i > 0; i--) begin
                a_res[i] <= a_res[i-1];
                a_flg[i] <= a_flg[i-1];
            end
            a_res[0] <= cur_res;
            a_flg[0] <= cur_flg;
        end
        if (bus.issue_valid_i && bus.issue_ready_o && clk_en_i)
            sb.push_back('{tag: bus.issue_rd_i, data: cur_res, flags: cur_flg});
    end

    assign bus.add_result_i    = a_res[LAT-1];
    assign bus.add_invalid_i   = a_flg[LAT-1].invalid;
    assign bus.add_overflow_i  = a_flg[LAT-1].overflow;
    assign bus.add_underflow_i = a_flg[LAT-1].underflow;

    // Writeback monitor: compares popped entries and models sticky flags.
    always @(negedge clk_i) begin
        chk("fflags", bus.fflags_o, exp_ff);
        if (rst_i) begin
            sb.delete();
            exp_ff <= 3'b000;
        end else if (bus.wb_valid_o && bus.wb_ready_i) begin
            chk("sb_nonempty_at_pop", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                chk("wb_rd", bus.wb_rd_o, sb[0].tag);
                chk("wb_data", bus.wb_data_o, sb[0].data);
                chk("wb_flags", bus.wb_flags_o, sb[0].flags);
                exp_ff <= fp_exc_t'((bus.fflags_clr_i ? 3'b000 : exp_ff) | sb[0].flags);
                void'(sb.pop_front());
            end
        end else if (bus.fflags_clr_i) begin
            exp_ff <= 3'b000;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [TW-1:0] tag, input float_t res, input fp_exc_t flg);
        chk("issue_ready_before_issue", bus.issue_ready_o, 1'b1);
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = tag;
        cur_res           = res;
        cur_flg           = flg;
        cyc();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        @(negedge clk_i);
        while (!bus.wb_valid_o && n < 20) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic pop_one();
        cyc();
        bus.wb_ready_i = 1'b1;
        cyc();
        bus.wb_ready_i = 1'b0;
    endtask

    int n;

    initial begin
        rst_i = 1'b1;
        clk_en_i = 1'b1;
        bus.issue_valid_i = 1'b0;
        bus.issue_rd_i = 5'd0;
        bus.wb_ready_i = 1'b0;
        bus.fflags_clr_i = 1'b0;
        cur_res = 32'h0000_0000;
        cur_flg = 3'b000;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_issue_ready", bus.issue_ready_o, 1'b0);
        chk("reset_wb_valid", bus.wb_valid_o, 1'b0);
        chk("reset_fu_state", bus.fu_state_o, FU_FREE);
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_issue_ready", bus.issue_ready_o, 1'b1);

        // Single op through the pipeline.
        issue(5'd7, 32'h4040_0000, 3'b000);
        chk("t1_fu_busy", bus.fu_state_o, FU_BUSY);
        wait_wb(n);
        chk("t1_latency", n, LAT - BYP);
        chk("t1_rd", bus.wb_rd_o, 5'd7);
        chk("t1_data", bus.wb_data_o, 32'h4040_0000);
        chk("t1_flags", bus.wb_flags_o, 3'b000);
        repeat (BYP) @(negedge clk_i);
        chk("t1_fu_free", bus.fu_state_o, FU_FREE);
        pop_one();
        @(negedge clk_i);
        chk("t1_drained", bus.wb_valid_o, 1'b0);

        // Back-to-back issue until credits run out, then drain in order.
        for (int t = 1; t <= 4; t++) issue(TW'(t), 32'h3F80_0000 + 32'(t), 3'b000);
        chk("t2_ready_low_after_4", bus.issue_ready_o, 1'b0);
        repeat (6) cyc();
        @(negedge clk_i);
        chk("t2_wb_valid_full", bus.wb_valid_o, 1'b1);
        chk("t2_fu_free_full", bus.fu_state_o, FU_FREE);
        chk("t2_ready_low_full", bus.issue_ready_o, 1'b0);
        chk("t2_head_tag", bus.wb_rd_o, 5'd1);
        cyc();
        bus.wb_ready_i = 1'b1;
        cyc();
        chk("t2_ready_after_pop", bus.issue_ready_o, 1'b1);
        repeat (4) cyc();
        bus.wb_ready_i = 1'b0;
        @(negedge clk_i);
        chk("t2_drained", bus.wb_valid_o, 1'b0);

        // Clock-enable stall in flight.
        issue(5'd9, 32'h4100_0000, 3'b000);
        cyc();
        clk_en_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk_i);
            chk("t3_no_capture_stalled", bus.wb_valid_o, 1'b0);
            chk("t3_busy_stalled", bus.fu_state_o, FU_BUSY);
            cyc();
        end
        clk_en_i = 1'b1;
        wait_wb(n);
        chk("t3_latency", n, LAT - 1 - BYP);
        chk("t3_rd", bus.wb_rd_o, 5'd9);
        pop_one();

        // Sticky flags with a clear coinciding with the third pop.
        issue(5'd20, 32'h1111_1111, 3'b010);
        issue(5'd21, 32'h2222_2222, 3'b100);
        issue(5'd22, 32'h3333_3333, 3'b001);
        repeat (8) cyc();
        pop_one();
        @(negedge clk_i);
        chk("t4_fflags_pop1", bus.fflags_o, 3'b010);
        pop_one();
        @(negedge clk_i);
        chk("t4_fflags_pop2", bus.fflags_o, 3'b110);
        cyc();
        bus.wb_ready_i = 1'b1;
        bus.fflags_clr_i = 1'b1;
        cyc();
        bus.wb_ready_i = 1'b0;
        bus.fflags_clr_i = 1'b0;
        @(negedge clk_i);
        chk("t4_fflags_clr_pop3", bus.fflags_o, 3'b001);

        // Reset with ops in flight.
        issue(5'd4, 32'h4444_4444, 3'b001);
        issue(5'd5, 32'h5555_5555, 3'b100);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t5_ready_in_reset", bus.issue_ready_o, 1'b0);
        cyc();
        rst_i = 1'b0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk_i);
            chk("t5_no_wb_after_reset", bus.wb_valid_o, 1'b0);
            chk("t5_fu_free_after_reset", bus.fu_state_o, FU_FREE);
            cyc();
        end

        // Writeback always ready: entry visible for exactly one cycle.
        bus.wb_ready_i = 1'b1;
        issue(5'd12, 32'hC000_0000, 3'b001);
        wait_wb(n);
        chk("t6_latency", n, LAT - BYP);
        chk("t6_rd", bus.wb_rd_o, 5'd12);
        @(negedge clk_i);
        chk("t6_consumed", bus.wb_valid_o, 1'b0);
        bus.wb_ready_i = 1'b0;

        // Random traffic with stalls, back-pressure and flag clears.
        for (int k = 0; k < 300; k++) begin
            clk_en_i = ($urandom_range(0, 3) != 0);
            bus.wb_ready_i = 1'($urandom_range(0, 1));
            bus.fflags_clr_i = ($urandom_range(0, 15) == 0);
            if (bus.issue_ready_o && $urandom_range(0, 1) == 1) begin
                bus.issue_valid_i = 1'b1;
                bus.issue_rd_i = TW'($urandom);
                cur_res = $urandom;
                cur_flg = fp_exc_t'($urandom_range(0, 7));
            end else begin
                bus.issue_valid_i = 1'b0;
            end
            cyc();
        end
        bus.issue_valid_i = 1'b0;
        bus.fflags_clr_i = 1'b0;
        clk_en_i = 1'b1;
        bus.wb_ready_i = 1'b1;
        repeat (20) cyc();
        @(negedge clk_i);
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_wb_valid", bus.wb_valid_o, 1'b0);
        chk("drain_fu_free", bus.fu_state_o, FU_FREE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
